instr_register_pipe: RTL and testbench
======================================

# instr_register_pipe

Parametrised, pipelined successor of the lab instruction register. It stores DEPTH instruction words of {opcode, operand_a, operand_b, result}. The result is computed in a two-stage ALU pipeline before write-back. Reads are registered and carry per-entry written/stale status so the self-checking bench can score every access. It sits between the stimulus driver and the scoreboard in the lab testbench, in place of the fixed 32-entry register.

## Interface
Parameters:
- OP_W, 32, signed operand width; result width RES_W = 2*OP_W
- DEPTH, 32, number of entries (power of two, ≥ 2); ADDR_W = $clog2(DEPTH)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  reset, synchronous and active-low
- load_en  in  1  write request, sampled each rising edge
- write_pointer  in  ADDR_W  write address
- opcode  in  3  opcode_t: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7
- operand_a  in  OP_W  signed operand A
- operand_b  in  OP_W  signed operand B
- rd_en  in  1  read request, sampled each rising edge
- read_pointer  in  ADDR_W  read address
- rd_valid  out  1  instruction_word and flags are valid this cycle
- instruction_word  out  3+2*OP_W+RES_W  packed {opc, op_a, op_b, res}
- rd_empty  out  1  entry read has never been written since reset
- rd_stale  out  1  a write to the read address is in flight
- valid_count  out  ADDR_W+1  number of distinct entries written since reset

## Operation
- Pipeline: W1 registers {load_en, addr, opc, a, b}. W2 registers the W1 contents plus the ALU result. W2 writes the array and sets the entry's written bit.
- ALU on W1, result sign-extended/computed at RES_W, signed:
  - ZERO → 0
  - PASSA → a
  - PASSB → b
  - ADD → a+b
  - SUB → a−b
  - MULT → full a*b
  - DIV → a/b, truncating toward zero
  - MOD → a%b, sign follows a
  - DIV or MOD with b==0 → res=0
- Stored op_a/op_b are the raw operands; opc is stored as given.
- Read: when rd_en is sampled high, the next cycle outputs rd_valid=1 and the array contents as they stood before that edge.
  - rd_empty = NOT written[read_pointer].
  - When rd_empty=1, instruction_word is forced to 0.
- rd_stale=1 if read_pointer equals the address of any of:
  - a load sampled on the same edge;
  - a valid W1 entry;
  - a valid W2 entry.
- On a stale read, data is still the pre-write array value. There is no forwarding.
- valid_count increments when W2 writes an entry whose written bit was 0. Rewrites do not change it. It saturates at DEPTH.
- Back-to-back writes to the same address: the last one wins, in load order.
- Simultaneous read and write to different addresses are independent.

## Timing
- Write latency: load sampled at edge E0 → array updated at E2. A read sampled at E3 or later returns new data. Reads sampled at E0, E1 or E2 return old data with rd_stale=1.
- Read latency: 1 cycle. rd_valid is high only in the cycle after each sampled rd_en. Back-to-back reads give back-to-back rd_valid.
- Throughput: one write and one read per cycle, with no stalls.
- Reset (reset_n low at an edge):
  - Clears W1/W2 valid, all written bits and valid_count.
  - Outputs become rd_valid=0, instruction_word=0, rd_empty=0, rd_stale=0, valid_count=0.
  - Array data is not cleared; it is masked by the written bits.
- Reset mid-operation discards in-flight writes: a load in W1/W2 at the reset edge never lands.
- Loads and reads sampled while reset_n is low are ignored.
- Address wrap: pointers are ADDR_W bits; no out-of-range case exists.

## Test plan
- Reset, then read addr 5 → rd_valid=1, rd_empty=1, instruction_word=0, valid_count=0.
- Write addr 3: ADD, a=−7, b=12. Wait 3 cycles, read 3 → opc=ADD, op_a=−7, op_b=12, res=5, rd_empty=0, rd_stale=0, valid_count=1.
- Write DEPTH entries with incremental addresses, then read in decremental order. Every result matches the model: MULT a=−3, b=5 → −15; DIV 7/−2 → −3; MOD −7%3 → −1; DIV/MOD with b=0 → 0. Final valid_count=DEPTH.
- Write addr 9 (PASSA a=42) at E0 and read 9 at E0, E1, E2, E3 → first three reads rd_stale=1 with old/empty data; the E3 read gives op_a=42, res=42, rd_stale=0.
- Write addr 4 twice on consecutive cycles (res 1, then res 2) → a later read returns res=2; valid_count increments by 1 only.
- Load addr 6 at E0 and assert reset_n=0 at E1 → after reset, read 6 gives rd_empty=1 and valid_count=0. A random-order 40-write/40-read regression then shows zero mismatches.

Source files
------------

// File: rtl/instr_register_pipe.sv
// Instruction register: DEPTH entries of {opcode, operand_a, operand_b, result}, result from a 2-stage ALU pipe.
// Latency: a load sampled at edge E0 lands in the array at E2; read data appears 1 cycle after rd_en.
// Backpressure: none; one write and one read are accepted every cycle with no stalls.
module instr_register_pipe #(
    parameter int  OP_W   = 32,
    parameter int  DEPTH  = 32,
    localparam int RES_W  = 2 * OP_W,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int WORD_W = 3 + 2 * OP_W + RES_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] write_pointer,
    input  logic [2:0]        opcode,
    input  logic [OP_W-1:0]   operand_a,
    input  logic [OP_W-1:0]   operand_b,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] read_pointer,
    output logic              rd_valid,
    output logic [WORD_W-1:0] instruction_word,
    output logic              rd_empty,
    output logic              rd_stale,
    output logic [ADDR_W:0]   valid_count
);

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef struct packed {
        opcode_t                 opc;
        logic signed [OP_W-1:0]  op_a;
        logic signed [OP_W-1:0]  op_b;
        logic signed [RES_W-1:0] res;
    } word_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    // W1 stage: raw load request
    logic                    w1_vld;
    logic [ADDR_W-1:0]       w1_addr;
    opcode_t                 w1_opc;
    logic signed [OP_W-1:0]  w1_a;
    logic signed [OP_W-1:0]  w1_b;

    // W2 stage: complete word ready for write-back
    logic                    w2_vld;
    logic [ADDR_W-1:0]       w2_addr;
    word_t                   w2_word;

    // Storage; data is never cleared, the written bits mask it
    word_t                   mem [DEPTH];
    logic [DEPTH-1:0]        written;

    logic signed [RES_W-1:0] a_ext;
    logic signed [RES_W-1:0] b_ext;
    logic signed [RES_W-1:0] alu_res;
    logic                    hit;

    // ALU on the W1 operands, evaluated at full result width so MULT keeps every product bit
    always_comb begin
        a_ext   = {{OP_W{w1_a[OP_W-1]}}, w1_a};
        b_ext   = {{OP_W{w1_b[OP_W-1]}}, w1_b};
        alu_res = '0;
        case (w1_opc)
            ZERO:    alu_res = '0;
            PASSA:   alu_res = a_ext;
            PASSB:   alu_res = b_ext;
            ADD:     alu_res = a_ext + b_ext;
            SUB:     alu_res = a_ext - b_ext;
            MULT:    alu_res = a_ext * b_ext;
            // Division by zero yields 0 rather than an undefined value
            DIV:     if (b_ext != '0) alu_res = a_ext / b_ext;
            MOD:     if (b_ext != '0) alu_res = a_ext % b_ext;
            default: alu_res = '0;
        endcase
    end

    // A read is stale when any write to its address is sampled now or still in the pipe
    always_comb begin
        hit = (load_en && (write_pointer == read_pointer))
            || (w1_vld && (w1_addr == read_pointer))
            || (w2_vld && (w2_addr == read_pointer));
    end

    // Pipeline valids: reset drops in-flight writes, loads during reset are ignored
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w1_vld <= 1'b0;
            w2_vld <= 1'b0;
        end else begin
            w1_vld <= load_en;
            w2_vld <= w1_vld;
        end
    end

    // Pipeline payload, qualified by the valids above
    always_ff @(posedge clk) begin
        w1_addr <= write_pointer;
        w1_opc  <= opcode_t'(opcode);
        w1_a    <= operand_a;
        w1_b    <= operand_b;
        w2_addr <= w1_addr;
        w2_word <= '{opc: w1_opc, op_a: w1_a, op_b: w1_b, res: alu_res};
    end

    // Write-back from W2 into the array
    always_ff @(posedge clk) begin
        if (reset_n && w2_vld) begin
            mem[w2_addr] <= w2_word;
        end
    end

    // Written bits and distinct-entry count; rewrites leave the count unchanged
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            written     <= '0;
            valid_count <= '0;
        end else if (w2_vld) begin
            written[w2_addr] <= 1'b1;
            if (!written[w2_addr] && (valid_count != FULL_COUNT)) begin
                valid_count <= valid_count + 1'b1;
            end
        end
    end

    // Registered read port: returns pre-edge contents, no forwarding from the write pipe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_valid         <= 1'b0;
            instruction_word <= '0;
            rd_empty         <= 1'b0;
            rd_stale         <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_empty         <= !written[read_pointer];
                instruction_word <= written[read_pointer] ? mem[read_pointer] : '0;
                rd_stale         <= hit;
            end
        end
    end

endmodule

// File: tb/tb_instr_register_pipe.sv
// Bench for instr_register_pipe: directed vectors plus randomized traffic against a queue-based model.
// Latency: model lands each write two edges after its load and scores every read one cycle later.
// Backpressure: none; stimulus drives one potential write and read per cycle.
module tb_instr_register_pipe;

    localparam int OP_W   = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int WORD_W = 3 + 2 * OP_W + 2 * OP_W;

    logic              clk;
    logic              reset_n;
    logic              load_en;
    logic [ADDR_W-1:0] write_pointer;
    logic [2:0]        opcode;
    logic [OP_W-1:0]   operand_a;
    logic [OP_W-1:0]   operand_b;
    logic              rd_en;
    logic [ADDR_W-1:0] read_pointer;
    logic              rd_valid;
    logic [WORD_W-1:0] instruction_word;
    logic              rd_empty;
    logic              rd_stale;
    logic [ADDR_W:0]   valid_count;

    instr_register_pipe #(.OP_W(OP_W), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .rd_en            (rd_en),
        .read_pointer     (read_pointer),
        .rd_valid         (rd_valid),
        .instruction_word (instruction_word),
        .rd_empty         (rd_empty),
        .rd_stale         (rd_stale),
        .valid_count      (valid_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: landed contents plus an ordered list of writes still travelling
    typedef struct {
        int                land;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] word;
    } pend_t;

    pend_t             pend[$];
    logic [WORD_W-1:0] m_mem [DEPTH];
    bit                m_wr  [DEPTH];
    int                m_cnt = 0;
    int                ecnt  = 0;

    typedef struct {
        logic [2:0] opc;
        int         a;
        int         b;
        longint     res;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [2:0] opc, input int a, input int b);
        longint la;
        longint lb;
        longint r;
        la = a;
        lb = b;
        r  = 0;
        case (opc)
            3'd1: r = la;
            3'd2: r = lb;
            3'd3: r = la + lb;
            3'd4: r = la - lb;
            3'd5: r = la * lb;
            3'd6: r = (b == 0) ? 64'sd0 : la / lb;
            3'd7: r = (b == 0) ? 64'sd0 : la % lb;
            default: r = 0;
        endcase
        return r;
    endfunction

    // One clock: drive inputs, let the DUT sample, advance the model, score the outputs
    task automatic cyc(input logic ld, input logic [ADDR_W-1:0] wp, input logic [2:0] opc,
                       input int a, input int b, input logic rd, input logic [ADDR_W-1:0] rp,
                       input logic rst_n);
        logic              e_vld;
        logic              e_empty;
        logic              e_stale;
        logic [WORD_W-1:0] e_word;
        load_en       = ld;
        write_pointer = wp;
        opcode        = opc;
        operand_a     = a;
        operand_b     = b;
        rd_en         = rd;
        read_pointer  = rp;
        reset_n       = rst_n;
        @(posedge clk);
        e_vld   = rst_n && rd;
        e_empty = 1'b0;
        e_stale = 1'b0;
        e_word  = '0;
        if (rst_n && rd) begin
            e_empty = !m_wr[rp];
            e_word  = m_wr[rp] ? m_mem[rp] : '0;
            e_stale = ld && (wp == rp);
            foreach (pend[i]) if (pend[i].addr == rp) e_stale = 1'b1;
        end
        if (!rst_n) begin
            pend.delete();
            foreach (m_wr[i]) m_wr[i] = 1'b0;
            m_cnt = 0;
        end else begin
            while (pend.size() > 0 && pend[0].land == ecnt) begin
                if (!m_wr[pend[0].addr]) m_cnt++;
                m_wr[pend[0].addr]  = 1'b1;
                m_mem[pend[0].addr] = pend[0].word;
                void'(pend.pop_front());
            end
            if (ld) pend.push_back('{ecnt + 2, wp, {opc, a, b, ref_res(opc, a, b)}});
        end
        #1;
        chk($sformatf("rd_valid@%0d", ecnt), rd_valid, e_vld);
        chk($sformatf("valid_count@%0d", ecnt), valid_count, m_cnt);
        if (!rst_n || rd) begin
            chk($sformatf("word@%0d", ecnt), instruction_word, e_word);
            chk($sformatf("rd_empty@%0d", ecnt), rd_empty, e_empty);
            chk($sformatf("rd_stale@%0d", ecnt), rd_stale, e_stale);
        end
        ecnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 3'd0, 0, 0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        int          nw;
        int          nr;
        int          vc0;
        logic        ld;
        logic        rd;
        logic [2:0]  opc;
        int          a;
        int          b;

        load_en = 1'b0; write_pointer = '0; opcode = '0; operand_a = '0; operand_b = '0;
        rd_en = 1'b0; read_pointer = '0; reset_n = 1'b0;

        tbl[0]  = '{3'd5, -3, 5, -15};
        tbl[1]  = '{3'd6, 7, -2, -3};
        tbl[2]  = '{3'd7, -7, 3, -1};
        tbl[3]  = '{3'd6, 5, 0, 0};
        tbl[4]  = '{3'd7, -9, 0, 0};
        tbl[5]  = '{3'd4, 3, 10, -7};
        tbl[6]  = '{3'd2, 1, -8, -8};
        tbl[7]  = '{3'd0, 11, 22, 0};
        tbl[8]  = '{3'd3, 32'sh7fffffff, 1, 64'sd2147483648};
        tbl[9]  = '{3'd5, 32'sh80000000, 32'sh80000000, 64'sh4000000000000000};
        tbl[10] = '{3'd6, 32'sh80000000, -1, 64'sd2147483648};

        // Reset, then read an unwritten entry
        cyc(1'b1, 5'd5, 3'd3, 1, 1, 1'b1, 5'd5, 1'b0);
        cyc(1'b0, '0, 3'd0, 0, 0, 1'b0, '0, 1'b0);
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_word", instruction_word, '0);
        chk("reset_rd_empty", rd_empty, 1'b0);
        chk("reset_rd_stale", rd_stale, 1'b0);
        chk("reset_valid_count", valid_count, 0);
        cyc(1'b0, '0, 3'd0, 0, 0, 1'b1, 5'd5, 1'b1);
        chk("empty_rd_valid", rd_valid, 1'b1);
        chk("empty_rd_empty", rd_empty, 1'b1);
        chk("empty_word", instruction_word, '0);
        chk("empty_valid_count", valid_count, 0);

        // Single ADD write, read after three cycles
        cyc(1'b1, 5'd3, 3'd3, -7, 12, 1'b0, '0, 1'b1);
        idle(2);
        cyc(1'b0, '0, 3'd0, 0, 0, 1'b1, 5'd3, 1'b1);
        chk("add_opc", instruction_word[130:128], 3'd3);
        chk("add_op_a", instruction_word[127:96], $unsigned(-32'sd7));
        chk("add_op_b", instruction_word[95:64], 32'd12);
        chk("add_res", instruction_word[63:0], 64'd5);
        chk("add_rd_empty", rd_empty, 1'b0);
        chk("add_rd_stale", rd_stale, 1'b0);
        chk("add_valid_count", valid_count, 1);

        // Fill every entry (table vectors first), then read back in descending order
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 11) cyc(1'b1, i[ADDR_W-1:0], tbl[i].opc, tbl[i].a, tbl[i].b, 1'b0, '0, 1'b1);
            else cyc(1'b1, i[ADDR_W-1:0], 3'($urandom_range(0, 7)), int'($urandom_range(0, 200)) - 100,
                     int'($urandom_range(0, 20)) - 10, 1'b0, '0, 1'b1);
        end
        idle(2);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cyc(1'b0, '0, 3'd0, 0, 0, 1'b1, i[ADDR_W-1:0], 1'b1);
            if (i < 11) chk($sformatf("tbl_res[%0d]", i), instruction_word[63:0], $unsigned(tbl[i].res));
        end
        chk("full_valid_count", valid_count, DEPTH);

        // Read-during-write window on entry 9
        cyc(1'b1, 5'd9, 3'd1, 42, 0, 1'b1, 5'd9, 1'b1);
        chk("stale_e0", rd_stale, 1'b1);
        cyc(1'b0, '0, 3'd0, 0, 0, 1'b1, 5'd9, 1'b1);
        chk("stale_e1", rd_stale, 1'b1);
        cyc(1'b0, '0, 3'd0, 0, 0, 1'b1, 5'd9, 1'b1);
        chk("stale_e2", rd_stale, 1'b1);
        cyc(1'b0, '0, 3'd0, 0, 0, 1'b1, 5'd9, 1'b1);
        chk("stale_e3", rd_stale, 1'b0);
        chk("stale_e3_op_a", instruction_word[127:96], 32'd42);
        chk("stale_e3_res", instruction_word[63:0], 64'd42);

        // Reset one cycle after a load: the load must never land
        cyc(1'b1, 5'd6, 3'd3, 1, 2, 1'b0, '0, 1'b1);
        cyc(1'b0, '0, 3'd0, 0, 0, 1'b0, '0, 1'b0);
        idle(3);
        cyc(1'b0, '0, 3'd0, 0, 0, 1'b1, 5'd6, 1'b1);
        chk("discard_rd_empty", rd_empty, 1'b1);
        chk("discard_valid_count", valid_count, 0);

        // Two consecutive writes to entry 4: last wins, counted once
        vc0 = int'(valid_count);
        cyc(1'b1, 5'd4, 3'd1, 1, 0, 1'b0, '0, 1'b1);
        cyc(1'b1, 5'd4, 3'd1, 2, 0, 1'b0, '0, 1'b1);
        idle(2);
        cyc(1'b0, '0, 3'd0, 0, 0, 1'b1, 5'd4, 1'b1);
        chk("rewrite_res", instruction_word[63:0], 64'd2);
        chk("rewrite_valid_count", valid_count, vc0 + 1);

        // Randomized mix of 40 writes and 40 reads over a narrow address range
        nw = 0;
        nr = 0;
        for (int k = 0; k < 600 && (nw < 40 || nr < 40); k++) begin
            ld  = (nw < 40) && ($urandom_range(0, 1) == 1);
            rd  = (nr < 40) && ($urandom_range(0, 1) == 1);
            opc = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                a = int'($urandom);
                b = int'($urandom);
            end else begin
                a = int'($urandom_range(0, 60)) - 30;
                b = int'($urandom_range(0, 10)) - 5;
            end
            cyc(ld, 5'($urandom_range(0, 7)), opc, a, b, rd, 5'($urandom_range(0, 7)), 1'b1);
            if (ld) nw++;
            if (rd) nr++;
        end
        chk("random_writes_issued", nw, 40);
        chk("random_reads_issued", nr, 40);
        idle(3);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 3'd0, 0, 0, 1'b1, i[ADDR_W-1:0], 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
